// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring divider, one quotient bit per clock
// by shift-and-subtract, with a start/done handshake.
// Optional feature: define DIVIDER_SIGNED_EN for two's-complement operands
// (truncation toward zero, same latency). Undefined: unsigned only.
module shift_sub_divider #(
    parameter int unsigned NBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NBits-1:0] dividend,
    input  logic [NBits-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NBits-1:0] quotient,
    output logic [NBits-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned    CNT_W     = (NBits > 1) ? $clog2(NBits) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NBits - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    // Partial remainder. The top bit of the NBits+1 accumulator is always 0
    // between iterations (remainder < divisor), so only NBits are stored.
    logic [NBits-1:0] r_q, r_d;
    logic [NBits-1:0] q_q, q_d;
    logic [NBits-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d, dbz_d;
    logic [NBits-1:0] quot_d, rem_d;
    logic [NBits:0]   t, diff;
`ifdef DIVIDER_SIGNED_EN
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
`endif

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quot_d;
            remainder   <= rem_d;
            div_by_zero <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
`endif
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        quot_d  = quotient;
        rem_d   = remainder;
        dbz_d   = div_by_zero;
`ifdef DIVIDER_SIGNED_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
`endif
        t    = {r_q, q_q[NBits-1]};
        diff = t - {1'b0, d_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    r_d    = '0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    sign_a_d = dividend[NBits-1];
                    sign_b_d = divisor[NBits-1];
                    q_d      = dividend[NBits-1] ? -dividend : dividend;
                    d_d      = divisor[NBits-1] ? -divisor : divisor;
`else
                    q_d = dividend;
                    d_d = divisor;
`endif
                    state_d = (divisor == '0) ? FIN : RUN;
                end
            end

            RUN: begin
                if (!diff[NBits]) begin
                    r_d = diff[NBits-1:0];
                    q_d = {q_q[NBits-2:0], 1'b1};
                end else begin
                    r_d = t[NBits-1:0];
                    q_d = {q_q[NBits-2:0], 1'b0};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (d_q == '0) begin
                    // Q still holds the (absolute) dividend: no iterations ran
                    quot_d = '1;
                    dbz_d  = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                    rem_d  = sign_a_q ? -q_q : q_q;
`else
                    rem_d  = q_q;
`endif
                end else begin
`ifdef DIVIDER_SIGNED_EN
                    quot_d = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                    rem_d  = sign_a_q ? -r_q : r_q;
`else
                    quot_d = q_q;
                    rem_d  = r_q;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider (NBits = 8), unsigned build by
// default; the reference model follows DIVIDER_SIGNED_EN when defined.
module tb_shift_sub_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_sub_divider #(.NBits(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on integers
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z, output int lat);
`ifdef DIVIDER_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            q = N'(sa / sb); r = N'(sa % sb); z = 1'b0; lat = N + 1;
        end
`else
        int ua, ub;
        ua = int'(a);
        ub = int'(b);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            q = N'(ua / ub); r = N'(ua % ub); z = 1'b0; lat = N + 1;
        end
`endif
    endfunction

    // Waits (bounded) for done after the accepting edge; reports latency and busy errors
    task automatic wait_done(output int lat, output int busy_err);
        lat = -1;
        busy_err = 0;
        for (int i = 1; i <= 30; i++) begin
            if (busy !== 1'b1) busy_err++;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (busy !== 1'b0) busy_err++;
    endtask

    // Drives one accepted start, then waits for done
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int busy_err);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, busy_err);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [4] = '{8'd100, 8'd255, 8'd5, 8'd255};
        logic [N-1:0] tb [4] = '{8'd7, 8'd1, 8'd9, 8'd255};
        logic [N-1:0] eq [4] = '{8'd14, 8'd255, 8'd0, 8'd1};
        logic [N-1:0] er [4] = '{8'd2, 8'd0, 8'd5, 8'd0};
        int lat, berr;
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], lat, berr);
            n_cmp++;
            if (lat !== N + 1 || berr !== 0) begin
                n_fail++;
                $display("FAIL directed_timing %0d/%0d: got latency=%0d busy_err=%0d required %0d/0",
                         ta[k], tb[k], lat, berr, N + 1);
            end
            n_cmp++;
            if (quotient !== eq[k] || remainder !== er[k] || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d dbz=%b required q=%0d r=%0d dbz=0",
                         ta[k], tb[k], quotient, remainder, div_by_zero, eq[k], er[k]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || quotient !== eq[k] || remainder !== er[k]) begin
                n_fail++;
                $display("FAIL directed_hold %0d/%0d: got done=%b q=%0d r=%0d required done=0 q=%0d r=%0d",
                         ta[k], tb[k], done, quotient, remainder, eq[k], er[k]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, berr;
        run_op(8'd77, 8'd0, lat, berr);
        n_cmp++;
        if (lat !== 1 || berr !== 0) begin
            n_fail++;
            $display("FAIL dbz_timing: got latency=%0d busy_err=%0d required 1/0", lat, berr);
        end
        n_cmp++;
        if (quotient !== 8'hFF || remainder !== 8'd77 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dbz_result: got q=%h r=%0d dbz=%b required q=ff r=77 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd10; divisor = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (div_by_zero !== 1'b0 || quotient !== 8'hFF || remainder !== 8'd77) begin
            n_fail++;
            $display("FAIL dbz_clear_keep: got dbz=%b q=%h r=%0d required dbz=0 q=ff r=77",
                     div_by_zero, quotient, remainder);
        end
        wait_done(lat, berr);
        n_cmp++;
        if (lat !== N + 1 || quotient !== 8'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_next: got latency=%0d q=%0d r=%0d dbz=%b required 9 q=3 r=1 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start();
        int lat, extra;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;                     // E0
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(posedge clk); #1;                     // E0+3
        start = 1'b0;
        lat = -1;
        for (int i = 4; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat !== N + 1 || quotient !== 8'd14 || remainder !== 8'd2) begin
            n_fail++;
            $display("FAIL ignore_start: got latency=%0d q=%0d r=%0d required 9 q=14 r=2",
                     lat, quotient, remainder);
        end
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL ignore_no_second: got %0d busy/done cycles required 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        int lat, berr, extra;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;                     // E0
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;                     // E0+4
        rst = 1'b1;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done: got %0d done pulses required 0", extra);
        end
        run_op(8'd100, 8'd7, lat, berr);
        n_cmp++;
        if (lat !== N + 1 || berr !== 0 || quotient !== 8'd14 || remainder !== 8'd2) begin
            n_fail++;
            $display("FAIL midreset_fresh: got latency=%0d busy_err=%0d q=%0d r=%0d required 9/0 q=14 r=2",
                     lat, berr, quotient, remainder);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, eq, er;
        logic ez;
        int elat, lat, berr;
        for (int k = 0; k < 40; k++) begin
            a = N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            model(a, b, eq, er, ez, elat);
            run_op(a, b, lat, berr);
            n_cmp++;
            if (lat !== elat || berr !== 0 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                n_fail++;
                $display("FAIL random %h/%h: got lat=%0d berr=%0d q=%h r=%h z=%b required lat=%0d berr=0 q=%h r=%h z=%b",
                         a, b, lat, berr, quotient, remainder, div_by_zero, elat, eq, er, ez);
            end
            if (($urandom & 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b, eq, er;
        logic ez;
        int elat, ndone, bad_pos;
        a = N'($urandom); b = N'($urandom_range(1, 255));
        start = 1'b1; dividend = a; divisor = b;
        ndone = 0; bad_pos = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (k % (N + 2) != 0) bad_pos++;
                model(a, b, eq, er, ez, elat);
                n_cmp++;
                if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                    n_fail++;
                    $display("FAIL b2b_result %h/%h: got q=%h r=%h z=%b required q=%h r=%h z=%b",
                             a, b, quotient, remainder, div_by_zero, eq, er, ez);
                end
                a = N'($urandom); b = N'($urandom_range(1, 255));
                dividend = a; divisor = b;
                if (k == 40) start = 1'b0;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone !== 4 || bad_pos !== 0) begin
            n_fail++;
            $display("FAIL b2b_timing: got %0d dones (%0d misplaced) required 4 (0)", ndone, bad_pos);
        end
        repeat (N + 4) @(posedge clk);
        #1;
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [N-1:0] ta [3] = '{8'h9C, 8'd100, 8'h80};
        logic [N-1:0] tb [3] = '{8'd7, 8'hF9, 8'hFF};
        logic [N-1:0] eq [3] = '{8'hF2, 8'hF2, 8'h80};
        logic [N-1:0] er [3] = '{8'hFE, 8'h02, 8'h00};
        int lat, berr;
        for (int k = 0; k < 3; k++) begin
            run_op(ta[k], tb[k], lat, berr);
            n_cmp++;
            if (lat !== N + 1 || quotient !== eq[k] || remainder !== er[k] || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL signed %h/%h: got lat=%0d q=%h r=%h z=%b required 9 q=%h r=%h z=0",
                         ta[k], tb[k], lat, quotient, remainder, div_by_zero, eq[k], er[k]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_ignore_start();
        test_mid_reset();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
